position_integrator: RTL and testbench

Consumes particle records streamed from the source half of the double-buffered position memory. For each record it adds the per-step displacement and classifies the particle as staying in or leaving its cell. Staying particles are compacted into the destination half. Migrating particles are queued on a handshaked migration port toward the neighbour-cell exchange. It sits between the position-memory read sequencer and the position-memory write port / migration network, and it closes each step with a terminator record and `done`.

---
 rtl/position_integrator.sv | 221 ++++++++++++++++++++++
 tb/tb_position_integrator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/position_integrator.sv
// Two-stage position update: add displacement, wrap into the cell and classify. Locals are
// compacted into the destination half; migrants go out through a handshaked FIFO.
module position_integrator #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FRAC       = 24,
    parameter int unsigned DBSIZE     = 256,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_bank,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [3*WIDTH-1:0] i_in_pos,
    input  logic [3*WIDTH-1:0] i_in_vel,
    input  logic               i_in_last,
    output logic               o_wr_en,
    output logic [31:0]        o_wr_addr,
    output logic [3*WIDTH:0]   o_wr_data,
    output logic               o_mig_valid,
    input  logic               i_mig_ready,
    output logic [3*WIDTH-1:0] o_mig_pos,
    output logic [5:0]         o_mig_dir,
    output logic               o_done,
    output logic               o_overflow,
    output logic               o_range_err
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic signed [WIDTH:0] CELL     = (WIDTH+1)'(1) << FRAC;
    localparam logic signed [WIDTH:0] TWO_CELL = CELL + CELL;
    localparam logic signed [WIDTH:0] NEG_CELL = -CELL;
    localparam logic signed [WIDTH:0] ZERO     = '0;
    localparam logic [PW:0]           CNT_ONE  = 1;
    localparam logic [PW-1:0]         PTR_ONE  = 1;

    typedef enum logic [2:0] {IDLE, RUN, TERM, DRAIN, DONE} state_e;

    state_e r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_base;
    logic        r_last_acc;

    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic signed [WIDTH:0]   r_s1_sum [3];

    logic                    r_s2_valid;
    logic                    r_s2_mig;
    logic                    r_s2_last;
    logic [3*WIDTH-1:0]      r_s2_pos;
    logic [5:0]              r_s2_dir;

    logic [3*WIDTH+5:0]      r_fifo [FIFO_DEPTH];
    logic [PW-1:0]           r_rptr;
    logic [PW-1:0]           r_wptr;
    logic [PW:0]             r_fcnt;

    logic signed [WIDTH:0]   w_s [3];
    logic [1:0]              w_d [3];
    logic                    w_rerr;
    logic                    w_mig;
    logic [3*WIDTH-1:0]      w_pos;
    logic [5:0]              w_dir;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;

    // Keep room for the two records already in the pipeline plus the one being accepted.
    assign o_in_ready = (r_state == RUN) && !r_last_acc && !i_start
                        && ((32'(r_fcnt) + 32'd3) <= FIFO_DEPTH);
    assign w_accept   = i_in_valid && o_in_ready;

    always_comb begin
        w_rerr = 1'b0;
        w_pos  = '0;
        for (int a = 0; a < 3; a++) begin
            w_s[a] = r_s1_sum[a];
            w_d[a] = 2'b00;
            if (r_s1_sum[a] < NEG_CELL || r_s1_sum[a] >= TWO_CELL) begin
                w_rerr = 1'b1;
            end else if (r_s1_sum[a] < ZERO) begin
                w_d[a] = 2'b11;
                w_s[a] = r_s1_sum[a] + CELL;
            end else if (r_s1_sum[a] >= CELL) begin
                w_d[a] = 2'b01;
                w_s[a] = r_s1_sum[a] - CELL;
            end
        end
        // An out-of-range axis forces the whole record local with unwrapped coordinates.
        if (w_rerr) begin
            for (int a = 0; a < 3; a++) begin
                w_s[a] = r_s1_sum[a];
                w_d[a] = 2'b00;
            end
        end
        for (int a = 0; a < 3; a++) begin
            w_pos[a*WIDTH +: WIDTH] = w_s[a][WIDTH-1:0];
        end
        w_dir = {w_d[2], w_d[1], w_d[0]};
        w_mig = (w_dir != 6'b000000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            for (int a = 0; a < 3; a++) r_s1_sum[a] <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mig   <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_pos   <= '0;
            r_s2_dir   <= '0;
            r_last_acc <= 1'b0;
        end else if (i_start) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_last_acc <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last <= i_in_last;
                for (int a = 0; a < 3; a++) begin
                    r_s1_sum[a] <= $signed({i_in_pos[a*WIDTH+WIDTH-1], i_in_pos[a*WIDTH +: WIDTH]})
                                 + $signed({i_in_vel[a*WIDTH+WIDTH-1], i_in_vel[a*WIDTH +: WIDTH]});
                end
                if (i_in_last) r_last_acc <= 1'b1;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_mig   <= w_mig;
            r_s2_last  <= r_s1_last;
            r_s2_pos   <= w_pos;
            r_s2_dir   <= w_dir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_done      <= 1'b0;
            o_overflow  <= 1'b0;
            o_range_err <= 1'b0;
        end else if (i_start) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_base      <= i_bank ? 32'd0 : 32'(DBSIZE);
            o_wr_en     <= 1'b0;
            o_done      <= 1'b0;
            o_overflow  <= 1'b0;
            o_range_err <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            if (r_s1_valid && !w_mig) begin
                if (r_cnt < DBSIZE) begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= r_base + r_cnt;
                    o_wr_data <= {1'b1, w_pos};
                    r_cnt     <= r_cnt + 32'd1;
                end else begin
                    o_overflow <= 1'b1;
                end
            end
            if (r_s1_valid && w_rerr) o_range_err <= 1'b1;
            case (r_state)
                RUN: begin
                    // The pipeline is empty behind the last record, so the terminator can't collide.
                    if (r_s2_valid && r_s2_last) begin
                        r_state <= TERM;
                        if (r_cnt < DBSIZE) begin
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= r_base + r_cnt;
                            o_wr_data <= '0;
                        end
                    end
                end
                TERM:  r_state <= DRAIN;
                DRAIN: begin
                    if (r_fcnt == '0) begin
                        r_state <= DONE;
                        o_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_push = r_s2_valid && r_s2_mig;
    assign w_pop  = o_mig_valid && i_mig_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_fcnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else if (i_start) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= {r_s2_pos, r_s2_dir};
                r_wptr         <= r_wptr + PTR_ONE;
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
            if (w_push && !w_pop)      r_fcnt <= r_fcnt + CNT_ONE;
            else if (!w_push && w_pop) r_fcnt <= r_fcnt - CNT_ONE;
        end
    end

    assign o_mig_valid            = (r_fcnt != '0);
    assign {o_mig_pos, o_mig_dir} = r_fifo[r_rptr];

endmodule

// File: tb/tb_position_integrator.sv
// Scoreboard bench for position_integrator: expected writes and migrants are queued as
// records are driven, and checked as the DUT emits them.
module tb_position_integrator;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DBSIZE = 256;
    localparam longint      CELL   = 64'sd16777216;

    logic         clk;
    logic         rst;
    logic         i_start;
    logic         i_bank;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [95:0]  i_in_pos;
    logic [95:0]  i_in_vel;
    logic         i_in_last;
    logic         o_wr_en;
    logic [31:0]  o_wr_addr;
    logic [96:0]  o_wr_data;
    logic         o_mig_valid;
    logic         i_mig_ready;
    logic [95:0]  o_mig_pos;
    logic [5:0]   o_mig_dir;
    logic         o_done;
    logic         o_overflow;
    logic         o_range_err;

    position_integrator #(
        .WIDTH(WIDTH), .FRAC(24), .DBSIZE(DBSIZE), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_bank(i_bank),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_pos(i_in_pos),
        .i_in_vel(i_in_vel), .i_in_last(i_in_last), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_mig_valid(o_mig_valid),
        .i_mig_ready(i_mig_ready), .o_mig_pos(o_mig_pos), .o_mig_dir(o_mig_dir),
        .o_done(o_done), .o_overflow(o_overflow), .o_range_err(o_range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int unsigned mbase = 0;
    int unsigned mcnt  = 0;
    bit exp_ovf  = 0;
    bit exp_rerr = 0;

    logic [128:0] wq[$];
    logic [101:0] mq[$];
    logic [128:0] we;
    logic [101:0] me;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic, wrap by one cell, out-of-range records stay local unwrapped.
    function automatic void model(input logic [95:0] pos, input logic [95:0] vel,
                                  output bit is_local, output logic [95:0] opos,
                                  output logic [5:0] dir, output bit rerr);
        longint s [3];
        longint w;
        logic [1:0] d;
        rerr = 0;
        for (int a = 0; a < 3; a++) begin
            s[a] = longint'($signed(pos[a*32 +: 32])) + longint'($signed(vel[a*32 +: 32]));
            if (s[a] < -CELL || s[a] >= 2 * CELL) rerr = 1;
        end
        opos = '0;
        dir  = '0;
        for (int a = 0; a < 3; a++) begin
            w = s[a];
            d = 2'b00;
            if (!rerr) begin
                if (w < 0) begin
                    d = 2'b11;
                    w = w + CELL;
                end else if (w >= CELL) begin
                    d = 2'b01;
                    w = w - CELL;
                end
            end
            opos[a*32 +: 32] = w[31:0];
            dir[a*2 +: 2]    = d;
        end
        is_local = (dir == 6'b000000);
    endfunction

    always @(negedge clk) begin
        if (!rst && o_wr_en) begin
            if (wq.size() == 0) begin
                check_eq("wr_unexpected", 128'(1), 128'(0));
            end else begin
                we = wq.pop_front();
                check_eq("wr_addr", 128'(o_wr_addr), 128'(we[128:97]));
                check_eq("wr_data", 128'(o_wr_data), 128'(we[96:0]));
            end
        end
        if (!rst && o_mig_valid && i_mig_ready) begin
            if (mq.size() == 0) begin
                check_eq("mig_unexpected", 128'(1), 128'(0));
            end else begin
                me = mq.pop_front();
                check_eq("mig_pos", 128'(o_mig_pos), 128'(me[101:6]));
                check_eq("mig_dir", 128'(o_mig_dir), 128'(me[5:0]));
            end
        end
        if (!rst && i_in_valid && o_in_ready) n_acc++;
    end

    task automatic start_step(input bit bank);
        i_start = 1'b1;
        i_bank  = bank;
        @(posedge clk); #1;
        i_start = 1'b0;
        mbase    = bank ? 0 : DBSIZE;
        mcnt     = 0;
        exp_ovf  = 0;
        exp_rerr = 0;
        n_acc    = 0;
    endtask

    task automatic send(input logic [95:0] pos, input logic [95:0] vel, input bit last);
        bit loc;
        bit re;
        logic [95:0] op;
        logic [5:0] dir;
        model(pos, vel, loc, op, dir, re);
        if (re) exp_rerr = 1;
        if (loc) begin
            if (mcnt < DBSIZE) begin
                wq.push_back({32'(mbase + mcnt), 1'b1, op});
                mcnt++;
            end else begin
                exp_ovf = 1;
            end
        end else begin
            mq.push_back({op, dir});
        end
        if (last && mcnt < DBSIZE) wq.push_back({32'(mbase + mcnt), 97'b0});
        i_in_valid = 1'b1;
        i_in_pos   = pos;
        i_in_vel   = vel;
        i_in_last  = last;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (o_in_ready) break;
            if (n > 200) begin
                check_eq("accept_timeout", 128'(0), 128'(1));
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic finish_step(input string tag);
        for (int n = 0; n < 400 && !o_done; n++) @(negedge clk);
        check_eq({tag, "_done"}, 128'(o_done), 128'(1));
        check_eq({tag, "_overflow"}, 128'(o_overflow), 128'(exp_ovf));
        check_eq({tag, "_range_err"}, 128'(o_range_err), 128'(exp_rerr));
        check_eq({tag, "_wr_left"}, 128'(wq.size()), 128'(0));
        check_eq({tag, "_mig_left"}, 128'(mq.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic expect_mig(input string tag, input logic [5:0] dir, input logic [95:0] pos);
        @(negedge clk);
        check_eq({tag, "_mv_t1"}, 128'(o_mig_valid), 128'(0));
        @(negedge clk);
        check_eq({tag, "_mv_t2"}, 128'(o_mig_valid), 128'(0));
        @(negedge clk);
        check_eq({tag, "_mv_t3"}, 128'(o_mig_valid), 128'(1));
        check_eq({tag, "_dir"}, 128'(o_mig_dir), 128'(dir));
        check_eq({tag, "_pos"}, 128'(o_mig_pos), 128'(pos));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, 128'({o_in_ready, o_wr_en, o_wr_addr, o_mig_valid, o_mig_dir,
                                      o_done, o_overflow, o_range_err}), 128'(0));
        check_eq({tag, "_wr_data"}, 128'(o_wr_data), 128'(0));
        check_eq({tag, "_mig_pos"}, 128'(o_mig_pos), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_start = 1'b0; i_bank = 1'b0; i_in_valid = 1'b0;
        i_in_pos = '0; i_in_vel = '0; i_in_last = 1'b0; i_mig_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_ready", 128'(o_in_ready), 128'(0));

        // Single local record with explicit latency and terminator placement.
        start_step(0);
        send({32'h10, 32'h10, 32'h10}, {32'd3, 32'd2, 32'd1}, 1);
        i_in_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_lat1", 128'(o_wr_en), 128'(0));
        check_eq("t1_ready_after_last", 128'(o_in_ready), 128'(0));
        @(negedge clk);
        check_eq("t1_lat2", 128'(o_wr_en), 128'(1));
        check_eq("t1_addr", 128'(o_wr_addr), 128'(256));
        check_eq("t1_data", 128'(o_wr_data), 128'({1'b1, 32'h13, 32'h12, 32'h11}));
        @(negedge clk);
        check_eq("t1_term_en", 128'(o_wr_en), 128'(1));
        check_eq("t1_term_addr", 128'(o_wr_addr), 128'(257));
        finish_step("t1");

        // +x migrant.
        start_step(0);
        send({32'h200, 32'h100, 32'h00FF_FFFF}, {32'd0, 32'd0, 32'd2}, 1);
        i_in_valid = 1'b0;
        expect_mig("t2", 6'b000001, {32'h200, 32'h100, 32'h1});
        finish_step("t2");

        // Bank 1: locals start at address 0.
        start_step(1);
        send({32'h5, 32'h6, 32'h7}, {32'd1, 32'd1, 32'd1}, 0);
        send({32'h0, 32'h0, 32'h00FF_FFFF}, {32'd0, 32'd0, 32'd2}, 1);
        i_in_valid = 1'b0;
        finish_step("t2b");

        // -x and +y migrant.
        start_step(0);
        send({32'h42, 32'h00FF_FFFF, 32'h0}, {32'd0, 32'd1, 32'hFFFF_FFFF}, 1);
        i_in_valid = 1'b0;
        expect_mig("t3", 6'b000111, {32'h42, 32'h0, 32'h00FF_FFFF});
        finish_step("t3");

        // 20 migrants against a stalled exchange port.
        start_step(0);
        i_mig_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 20; i++) begin
                    send({32'h0, 32'(i), 32'h00FF_FFFF}, {32'd0, 32'd0, 32'(i)}, i == 20);
                end
                i_in_valid = 1'b0;
            end
            begin
                repeat (40) @(posedge clk);
                #1;
                check_eq("t4_accepted", 128'(n_acc), 128'(16));
                check_eq("t4_ready_low", 128'(o_in_ready), 128'(0));
                check_eq("t4_mig_valid", 128'(o_mig_valid), 128'(1));
                check_eq("t4_no_done", 128'(o_done), 128'(0));
                i_mig_ready = 1'b1;
            end
        join
        finish_step("t4");

        // Destination half fills up: last record dropped, no terminator.
        start_step(0);
        for (int i = 0; i <= 256; i++) begin
            send({32'h3, 32'h2, 32'(i)}, {32'd0, 32'd0, 32'd1}, i == 256);
        end
        i_in_valid = 1'b0;
        finish_step("t5");

        // Out-of-range displacement; flags from the previous step must be cleared.
        start_step(0);
        check_eq("t5b_ovf_cleared", 128'(o_overflow), 128'(0));
        send({32'h10, 32'h10, 32'h10}, {32'd0, 32'd0, 32'h0200_0000}, 1);
        i_in_valid = 1'b0;
        finish_step("t5b");

        // Reset in the middle of a step with migrants queued.
        start_step(0);
        i_mig_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send({32'h0, 32'h0, 32'h00FF_FFFF}, {32'd0, 32'd0, 32'(i + 1)}, 0);
        end
        i_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t6_queued", 128'(o_mig_valid), 128'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        wq.delete();
        mq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        i_mig_ready = 1'b1;
        @(posedge clk); #1;
        start_step(0);
        send({32'h20, 32'h20, 32'h20}, {32'd1, 32'd1, 32'd1}, 1);
        i_in_valid = 1'b0;
        finish_step("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
